booth_mult_pipe: RTL and testbench

BOOTH_MULT_PIPE -- requirements
Module: booth_mult_pipe

---
 rtl/booth_mult_pipe.sv | 172 +++++++++++++++++
 tb/tb_booth_mult_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_pipe.sv
// booth_mult_pipe: radix-2 Booth two's-complement multiplier, one step per cycle.
// Define BOOTH_MULT_UNSIGNED_EN to add is_signed for unsigned operation.
module booth_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_q,
  input  logic [WIDTH-1:0]   in_m,
`ifdef BOOTH_MULT_UNSIGNED_EN
  input  logic               is_signed,
`endif
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

`ifdef BOOTH_MULT_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int AW = QW + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] a_q, a_d;
  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] m_q, m_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prod_q, prod_d;

  logic          accept;
  logic          last;
  logic [QW-1:0] q_load;
  logic [QW-1:0] m_load;
  logic [CW-1:0] n_load;
  logic [AW-1:0] m_ext;
  logic [AW-1:0] sum;
  logic [AW+QW-1:0] sh;
  logic [PW-1:0] result;

  assign accept = start & (state_q != RUN);
  assign last   = (cnt_q == CW'(1));

`ifdef BOOTH_MULT_UNSIGNED_EN
  logic sgn_q, sgn_d;

  // Unsigned operands become positive (W+1)-bit signed values.
  assign q_load = {is_signed & in_q[WIDTH-1], in_q};
  assign m_load = {is_signed & in_m[WIDTH-1], in_m};
  assign n_load = is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
  // A signed run does one shift fewer, so the product sits one bit higher.
  assign result = sgn_q ? sh[PW:1] : sh[PW-1:0];
`else
  assign q_load = in_q;
  assign m_load = in_m;
  assign n_load = CW'(WIDTH);
  assign result = sh[PW-1:0];
`endif

  assign m_ext = {m_q[QW-1], m_q};

  always_comb begin
    sum = a_q;
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
  end

  assign sh = {sum[AW-1], sum, q_q[QW-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      RUN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    q1_d   = q1_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
`ifdef BOOTH_MULT_UNSIGNED_EN
    sgn_d  = sgn_q;
`endif
    if (accept) begin
      a_d   = '0;
      q_d   = q_load;
      m_d   = m_load;
      q1_d  = 1'b0;
      cnt_d = n_load;
`ifdef BOOTH_MULT_UNSIGNED_EN
      sgn_d = is_signed;
`endif
    end else if (state_q == RUN) begin
      a_d   = sh[AW+QW-1:QW];
      q_d   = sh[QW-1:0];
      q1_d  = q_q[0];
      cnt_d = cnt_q - CW'(1);
      if (last) prod_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
`ifdef BOOTH_MULT_UNSIGNED_EN
      sgn_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      q1_q   <= q1_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
`ifdef BOOTH_MULT_UNSIGNED_EN
      sgn_q  <= sgn_d;
`endif
    end
  end

  assign prod = prod_q;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// tb_booth_mult_pipe: directed vectors plus a cycle-level reference model
// for booth_mult_pipe at WIDTH=8.
module tb_booth_mult_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_q;
  logic [W-1:0] in_m;
  logic         is_signed;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [2*W-1:0] prod;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  booth_mult_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_q     (in_q),
    .in_m     (in_m),
`ifdef BOOTH_MULT_UNSIGNED_EN
    .is_signed(is_signed),
`endif
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .prod     (prod)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
    int sa;
    int sb;
`ifdef BOOTH_MULT_UNSIGNED_EN
    if (!s) return 16'(int'(a) * int'(b));
`endif
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  function automatic int ref_lat(input logic s);
`ifdef BOOTH_MULT_UNSIGNED_EN
    if (!s) return W + 1;
`endif
    return W;
  endfunction

  // Reference: an accepted op stays busy for its latency, then pulses done.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_pend = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_prod <= m_pend;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left <= ref_lat(is_signed);
        m_pend <= ref_mul(in_q, in_m, is_signed);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_ready", 32'(in_ready), 32'(m_left == 0));
      chk("cyc_busy", 32'(busy), 32'(m_left > 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_prod", 32'(prod), 32'(m_prod));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic op(input string nm, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic s,
                    input logic [15:0] exp, input int lat);
    int n;
    @(posedge clk);
    #1;
    in_q = a;
    in_m = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_prod"}, 32'(prod), 32'(exp));
  endtask

  initial begin
    int n;
    logic saw;
    rst = 1'b1;
    start = 1'b0;
    in_q = '0;
    in_m = '0;
    is_signed = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_prod", 32'(prod), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    op("p3xm5", 8'h03, 8'hFB, 1'b1, 16'hFFF1, 8);
    op("m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
    op("p127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080, 8);
    op("m128xp127", 8'h80, 8'h7F, 1'b1, 16'hC080, 8);
    op("p127sq", 8'h7F, 8'h7F, 1'b1, 16'h3F01, 8);
    op("m1xm128", 8'hFF, 8'h80, 1'b1, 16'h0080, 8);
    op("zero", 8'h00, 8'h55, 1'b1, 16'h0000, 8);

    // start during RUN is ignored
    @(posedge clk);
    #1;
    in_q = 8'h12;
    in_m = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ign_ready", 32'(in_ready), 32'h0);
    in_q = 8'h55;
    in_m = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    chk("ign_lat", 32'(n + 3), 32'd8);
    chk("ign_prod", 32'(prod), 32'h03A8);

    // reset mid-operation
    @(posedge clk);
    #1;
    in_q = 8'h09;
    in_m = 8'h0B;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_prod", 32'(prod), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(in_ready), 32'h1);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      saw = saw | done;
    end
    chk("abort_nodone", 32'(saw), 32'h0);
    rst = 1'b1;
    op("after_rst", 8'h11, 8'h22, 1'b1, 16'h0242, 8);

    // back-to-back through DONE
    @(posedge clk);
    #1;
    in_q = 8'h05;
    in_m = 8'h06;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    chk("b2b1_lat", 32'(n), 32'd8);
    chk("b2b1_prod", 32'(prod), 32'h001E);
    in_q = 8'hF9;
    in_m = 8'h09;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_nobubble", 32'(busy), 32'h1);
    chk("b2b_hold", 32'(prod), 32'h001E);
    wait_done(n);
    chk("b2b2_lat", 32'(n), 32'd8);
    chk("b2b2_prod", 32'(prod), 32'hFFC1);

`ifdef BOOTH_MULT_UNSIGNED_EN
    op("u255sq", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
    op("s255sq", 8'hFF, 8'hFF, 1'b1, 16'h0001, 8);
    op("u128sq", 8'h80, 8'h80, 1'b0, 16'h4000, 9);
`else
    op("s255sq", 8'hFF, 8'hFF, 1'b1, 16'h0001, 8);
`endif

    repeat (3) @(posedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
